// File: rtl/mem_arb_pkg.sv
// Shared types for the two-client memory-bus arbiter.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Widths of the registered response packet; they match the arbiter's default bus widths.
    localparam int RSP_DATA_W = 64;
    localparam int RSP_TAG_W  = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    typedef enum logic {
        CLI_ICACHE = 1'b0,
        CLI_DCACHE = 1'b1
    } client_e;

    typedef struct packed {
        logic                  valid;
        logic [RSP_DATA_W-1:0] data;
        logic [RSP_TAG_W-1:0]  tag;
    } rsp_pkt_t;

    // The tie-break winner is always the client that did not win last time.
    function automatic client_e other_client(input client_e c);
        return (c == CLI_ICACHE) ? CLI_DCACHE : CLI_ICACHE;
    endfunction

endpackage

// File: rtl/mem_tag_table.sv
// Per-tag busy/owner table for outstanding memory loads; lookup is combinational, updates land on the next edge.
// Latency: free/lookup result is available in the same cycle; allocations and frees are visible one cycle later.
// Backpressure: none, because every alloc and free is taken. Misuse is flagged on orphan_o and collision_o.
// Ports: clk/reset_n; alloc_* marks an entry busy with its owner; free_* looks up and releases an entry.
module mem_tag_table
    import mem_arb_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alloc_vld_i,
    input  logic [TAG_W-1:0] alloc_tag_i,
    input  client_e          alloc_owner_i,
    input  logic             free_vld_i,
    input  logic [TAG_W-1:0] free_tag_i,
    output logic             free_hit_o,
    output client_e          free_owner_o,
    output logic             orphan_o,
    output logic             collision_o
);

    localparam int N = 2 ** TAG_W;

    logic [N-1:0] busy_q, busy_d;
    logic [N-1:0] owner_q, owner_d;   // 1 = dcache owns the tag

    assign free_hit_o   = free_vld_i && busy_q[free_tag_i];
    assign free_owner_o = owner_q[free_tag_i] ? CLI_DCACHE : CLI_ICACHE;
    assign orphan_o     = free_vld_i && !busy_q[free_tag_i];
    // A tag that is returned and re-issued in the same cycle is a legal turnaround.
    // It is not a collision.
    assign collision_o  = alloc_vld_i && busy_q[alloc_tag_i] &&
                          !(free_hit_o && (free_tag_i == alloc_tag_i));

    // The free is applied before the alloc.
    // As a result, a same-tag turnaround ends busy and owned by the new client.
    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        if (free_hit_o) begin
            busy_d[free_tag_i] = 1'b0;
        end
        if (alloc_vld_i) begin
            busy_d[alloc_tag_i]  = 1'b1;
            owner_d[alloc_tag_i] = (alloc_owner_i == CLI_DCACHE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q  <= '0;
            owner_q <= '0;
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin icache/dcache arbiter onto one proc2mem bus. Tagged load returns are steered back to their owner.
// Latency: issue and accept are combinational in the request cycle; a load return reaches the client one cycle after mem2proc_tag.
// Backpressure: a refused request (mem2proc_response==0) stays un-accepted and is re-arbitrated. Loads are capped per client.
// Ports: icache_req_*/icache_rsp_*, dcache_req_*/dcache_rsp_*, proc2mem_* bus out, mem2proc_* bus in, sticky err_orphan.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int TAG_W     = 4,
    parameter int MAX_OUT_I = 4,
    parameter int MAX_OUT_D = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              icache_req_valid,
    input  logic [ADDR_W-1:0] icache_req_addr,
    output logic              icache_req_accept,
    output logic [TAG_W-1:0]  icache_req_tag,
    output logic              icache_rsp_valid,
    output logic [DATA_W-1:0] icache_rsp_data,
    output logic [TAG_W-1:0]  icache_rsp_tag,
    input  logic              dcache_req_valid,
    input  logic [1:0]        dcache_req_cmd,
    input  logic [ADDR_W-1:0] dcache_req_addr,
    input  logic [DATA_W-1:0] dcache_req_data,
    output logic              dcache_req_accept,
    output logic [TAG_W-1:0]  dcache_req_tag,
    output logic              dcache_rsp_valid,
    output logic [DATA_W-1:0] dcache_rsp_data,
    output logic [TAG_W-1:0]  dcache_rsp_tag,
    output logic [1:0]        proc2mem_command,
    output logic [ADDR_W-1:0] proc2mem_addr,
    output logic [DATA_W-1:0] proc2mem_data,
    input  logic [TAG_W-1:0]  mem2proc_response,
    input  logic [DATA_W-1:0] mem2proc_data,
    input  logic [TAG_W-1:0]  mem2proc_tag,
    output logic              err_orphan
);

    localparam int CNT_I_W = $clog2(MAX_OUT_I + 1);
    localparam int CNT_D_W = $clog2(MAX_OUT_D + 1);
    localparam logic [CNT_I_W-1:0] CAP_I = CNT_I_W'(MAX_OUT_I);
    localparam logic [CNT_D_W-1:0] CAP_D = CNT_D_W'(MAX_OUT_D);

    logic [CNT_I_W-1:0] cnt_i_q, cnt_i_d;
    logic [CNT_D_W-1:0] cnt_d_q, cnt_d_d;
    client_e            last_grant_q, last_grant_d;
    rsp_pkt_t           irsp_q, irsp_d, drsp_q, drsp_d;
    logic               err_orphan_q, err_orphan_d;

    bus_cmd_e dcmd;
    bus_cmd_e issue_cmd;
    client_e  win_cli;
    logic     elig_i, elig_d, win_vld, accept, load_acc;
    logic     free_hit, orphan, collision;
    client_e  free_owner;
    logic     inc_i, dec_i, inc_d, dec_d;

    assign dcmd = bus_cmd_e'(dcache_req_cmd);

    // Stores never hold a tag, so they bypass the load cap.
    assign elig_i = icache_req_valid && (cnt_i_q < CAP_I);
    assign elig_d = dcache_req_valid && ((dcmd == BUS_STORE) || (cnt_d_q < CAP_D));

    always_comb begin
        win_vld = elig_i || elig_d;
        win_cli = CLI_ICACHE;
        if (elig_i && elig_d) begin
            win_cli = other_client(last_grant_q);
        end else if (elig_d) begin
            win_cli = CLI_DCACHE;
        end
    end

    // The bus is driven from requests and registered state only, never from mem2proc_*.
    always_comb begin
        issue_cmd     = BUS_NONE;
        proc2mem_addr = '0;
        proc2mem_data = '0;
        if (win_vld) begin
            if (win_cli == CLI_ICACHE) begin
                issue_cmd     = BUS_LOAD;
                proc2mem_addr = icache_req_addr;
            end else begin
                issue_cmd     = dcmd;
                proc2mem_addr = dcache_req_addr;
                proc2mem_data = dcache_req_data;
            end
        end
    end

    assign proc2mem_command = issue_cmd;

    assign accept            = win_vld && (mem2proc_response != '0);
    assign load_acc          = accept && (issue_cmd == BUS_LOAD);
    assign icache_req_accept = accept && (win_cli == CLI_ICACHE);
    assign dcache_req_accept = accept && (win_cli == CLI_DCACHE);
    assign icache_req_tag    = icache_req_accept ? mem2proc_response : '0;
    assign dcache_req_tag    = dcache_req_accept ? mem2proc_response : '0;

    mem_tag_table #(
        .TAG_W (TAG_W)
    ) u_tag_table (
        .clk           (clk),
        .reset_n       (reset_n),
        .alloc_vld_i   (load_acc),
        .alloc_tag_i   (mem2proc_response),
        .alloc_owner_i (win_cli),
        .free_vld_i    (mem2proc_tag != '0),
        .free_tag_i    (mem2proc_tag),
        .free_hit_o    (free_hit),
        .free_owner_o  (free_owner),
        .orphan_o      (orphan),
        .collision_o   (collision)
    );

    assign inc_i = load_acc && (win_cli == CLI_ICACHE);
    assign inc_d = load_acc && (win_cli == CLI_DCACHE);
    assign dec_i = free_hit && (free_owner == CLI_ICACHE);
    assign dec_d = free_hit && (free_owner == CLI_DCACHE);

    always_comb begin
        cnt_i_d = cnt_i_q;
        if (inc_i && !dec_i) begin
            cnt_i_d = cnt_i_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            cnt_i_d = cnt_i_q - 1'b1;
        end
        cnt_d_d = cnt_d_q;
        if (inc_d && !dec_d) begin
            cnt_d_d = cnt_d_q + 1'b1;
        end else if (dec_d && !inc_d) begin
            cnt_d_d = cnt_d_q - 1'b1;
        end
    end

    // Response packets are all-zero unless valid, so data and tag outputs stay quiet between returns.
    always_comb begin
        irsp_d = '0;
        drsp_d = '0;
        if (free_hit) begin
            if (free_owner == CLI_ICACHE) begin
                irsp_d.valid = 1'b1;
                irsp_d.data  = RSP_DATA_W'(mem2proc_data);
                irsp_d.tag   = RSP_TAG_W'(mem2proc_tag);
            end else begin
                drsp_d.valid = 1'b1;
                drsp_d.data  = RSP_DATA_W'(mem2proc_data);
                drsp_d.tag   = RSP_TAG_W'(mem2proc_tag);
            end
        end
    end

    assign err_orphan_d = err_orphan_q || orphan || collision;
    assign last_grant_d = accept ? win_cli : last_grant_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_i_q      <= '0;
            cnt_d_q      <= '0;
            last_grant_q <= CLI_ICACHE;
            irsp_q       <= '0;
            drsp_q       <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            cnt_i_q      <= cnt_i_d;
            cnt_d_q      <= cnt_d_d;
            last_grant_q <= last_grant_d;
            irsp_q       <= irsp_d;
            drsp_q       <= drsp_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign icache_rsp_valid = irsp_q.valid;
    assign icache_rsp_data  = DATA_W'(irsp_q.data);
    assign icache_rsp_tag   = TAG_W'(irsp_q.tag);
    assign dcache_rsp_valid = drsp_q.valid;
    assign dcache_rsp_data  = DATA_W'(drsp_q.data);
    assign dcache_rsp_tag   = TAG_W'(drsp_q.tag);
    assign err_orphan       = err_orphan_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Load returns are checked against a queue of expected responses.
// Latency: a return driven before edge N is expected on the rsp outputs just after edge N.
// Backpressure: refusals are exercised by driving mem2proc_response to 0.
module tb_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_accept;
    logic [3:0]  icache_req_tag;
    logic        icache_rsp_valid;
    logic [63:0] icache_rsp_data;
    logic [3:0]  icache_rsp_tag;
    logic        dcache_req_valid;
    logic [1:0]  dcache_req_cmd;
    logic [31:0] dcache_req_addr;
    logic [63:0] dcache_req_data;
    logic        dcache_req_accept;
    logic [3:0]  dcache_req_tag;
    logic        dcache_rsp_valid;
    logic [63:0] dcache_rsp_data;
    logic [3:0]  dcache_rsp_tag;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic        err_orphan;

    typedef struct {
        bit          dcache;
        logic [63:0] data;
        logic [3:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mem_arbiter dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .icache_req_valid  (icache_req_valid),
        .icache_req_addr   (icache_req_addr),
        .icache_req_accept (icache_req_accept),
        .icache_req_tag    (icache_req_tag),
        .icache_rsp_valid  (icache_rsp_valid),
        .icache_rsp_data   (icache_rsp_data),
        .icache_rsp_tag    (icache_rsp_tag),
        .dcache_req_valid  (dcache_req_valid),
        .dcache_req_cmd    (dcache_req_cmd),
        .dcache_req_addr   (dcache_req_addr),
        .dcache_req_data   (dcache_req_data),
        .dcache_req_accept (dcache_req_accept),
        .dcache_req_tag    (dcache_req_tag),
        .dcache_rsp_valid  (dcache_rsp_valid),
        .dcache_rsp_data   (dcache_rsp_data),
        .dcache_rsp_tag    (dcache_rsp_tag),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag),
        .err_orphan        (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    // Settle combinational outputs after driving inputs, away from the clock edge.
    task automatic settle();
        #2;
    endtask

    task automatic chk_issue(input string name, input logic [1:0] cmd, input logic [31:0] addr,
                             input logic [63:0] data, input bit iacc, input bit dacc,
                             input logic [3:0] tag);
        chk({name, "_cmd"},  proc2mem_command, cmd);
        chk({name, "_addr"}, proc2mem_addr, addr);
        chk({name, "_data"}, proc2mem_data, data);
        chk({name, "_iacc"}, icache_req_accept, iacc);
        chk({name, "_dacc"}, dcache_req_accept, dacc);
        chk({name, "_itag"}, icache_req_tag, iacc ? tag : 4'd0);
        chk({name, "_dtag"}, dcache_req_tag, dacc ? tag : 4'd0);
    endtask

    // Advance one edge, retire the one-cycle return, and score the response outputs.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        mem2proc_tag  = 4'd0;
        mem2proc_data = 64'd0;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_ivld", icache_rsp_valid, !e.dcache);
            chk("rsp_dvld", dcache_rsp_valid, e.dcache);
            chk("rsp_data", e.dcache ? dcache_rsp_data : icache_rsp_data, e.data);
            chk("rsp_tag",  e.dcache ? dcache_rsp_tag : icache_rsp_tag, e.tag);
            chk("rsp_other_data", e.dcache ? icache_rsp_data : dcache_rsp_data, 64'd0);
        end else begin
            chk("idle_ivld", icache_rsp_valid, 1'b0);
            chk("idle_dvld", dcache_rsp_valid, 1'b0);
            chk("idle_idata", icache_rsp_data, 64'd0);
            chk("idle_dtag", dcache_rsp_tag, 4'd0);
        end
    endtask

    task automatic ret(input logic [3:0] tag, input logic [63:0] data, input bit push, input bit to_d);
        exp_t e;
        mem2proc_tag  = tag;
        mem2proc_data = data;
        if (push) begin
            e.dcache = to_d;
            e.data   = data;
            e.tag    = tag;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        icache_req_valid  = 1'b0;
        icache_req_addr   = 32'd0;
        dcache_req_valid  = 1'b0;
        dcache_req_cmd    = 2'd0;
        dcache_req_addr   = 32'd0;
        dcache_req_data   = 64'd0;
        mem2proc_response = 4'd0;
    endtask

    task automatic do_reset();
        idle();
        mem2proc_tag  = 4'd0;
        mem2proc_data = 64'd0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic dreq(input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] data);
        dcache_req_valid = 1'b1;
        dcache_req_cmd   = cmd;
        dcache_req_addr  = addr;
        dcache_req_data  = data;
    endtask

    task automatic ireq(input logic [31:0] addr);
        icache_req_valid = 1'b1;
        icache_req_addr  = addr;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        mem2proc_tag  = 4'd0;
        mem2proc_data = 64'd0;
        #3;
        chk("rst_cmd", proc2mem_command, 2'd0);
        chk("rst_ivld", icache_rsp_valid, 1'b0);
        chk("rst_dvld", dcache_rsp_valid, 1'b0);
        chk("rst_err", err_orphan, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Tie after reset: dcache first, held through a refusal, then icache.
        ireq(32'h100);
        dreq(2'd1, 32'h200, 64'd0);
        mem2proc_response = 4'd0;
        settle();
        chk_issue("tie_refuse", 2'd1, 32'h200, 64'd0, 1'b0, 1'b0, 4'd0);
        cyc();
        mem2proc_response = 4'd7;
        settle();
        chk_issue("tie_retry", 2'd1, 32'h200, 64'd0, 1'b0, 1'b1, 4'd7);
        cyc();
        dreq(2'd1, 32'h208, 64'd0);
        mem2proc_response = 4'd8;
        settle();
        chk_issue("tie_second", 2'd1, 32'h100, 64'd0, 1'b1, 1'b0, 4'd8);
        cyc();
        idle();
        ret(4'd8, 64'h88, 1'b1, 1'b0);
        cyc();
        ret(4'd7, 64'h77, 1'b1, 1'b1);
        cyc();

        // Icache load: combinational accept/tag, data back one cycle after the return.
        ireq(32'h40);
        mem2proc_response = 4'd3;
        settle();
        chk_issue("iload", 2'd1, 32'h40, 64'd0, 1'b1, 1'b0, 4'd3);
        cyc();
        idle();
        ret(4'd3, 64'd233, 1'b1, 1'b0);
        cyc();
        cyc();

        // Store: allocates nothing, so its tag returning later is an orphan.
        chk("store_err_before", err_orphan, 1'b0);
        dreq(2'd2, 32'd4, 64'd996);
        mem2proc_response = 4'd5;
        settle();
        chk_issue("store", 2'd2, 32'd4, 64'd996, 1'b0, 1'b1, 4'd5);
        cyc();
        idle();
        chk("store_cnt_d", dut.cnt_d_q, 64'd0);
        ret(4'd5, 64'h55, 1'b0, 1'b0);
        cyc();
        chk("store_orphan", err_orphan, 1'b1);

        // Icache cap of four outstanding loads.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            ireq(32'h1000 + 32'(k) * 32'h40);
            mem2proc_response = 4'(k);
            settle();
            chk("cap_fill_acc", icache_req_accept, 1'b1);
            cyc();
        end
        chk("cap_cnt_i", dut.cnt_i_q, 64'd4);
        ireq(32'h1140);
        mem2proc_response = 4'd0;
        settle();
        chk_issue("cap_blocked", 2'd0, 32'd0, 64'd0, 1'b0, 1'b0, 4'd0);
        dreq(2'd2, 32'h30, 64'h1234);
        mem2proc_response = 4'd9;
        settle();
        chk_issue("cap_dstore", 2'd2, 32'h30, 64'h1234, 1'b0, 1'b1, 4'd9);
        cyc();
        dcache_req_valid  = 1'b0;
        mem2proc_response = 4'd0;
        ret(4'd1, 64'h1111, 1'b1, 1'b0);
        settle();
        chk("cap_still_blocked", proc2mem_command, 2'd0);
        cyc();
        mem2proc_response = 4'd1;
        settle();
        chk_issue("cap_fifth", 2'd1, 32'h1140, 64'd0, 1'b1, 1'b0, 4'd1);
        cyc();
        idle();
        chk("cap_err_clean", err_orphan, 1'b0);

        // Same-tag turnaround: tag 2 returns to icache while dcache re-takes it.
        dreq(2'd1, 32'h500, 64'd0);
        mem2proc_response = 4'd2;
        ret(4'd2, 64'h2222, 1'b1, 1'b0);
        settle();
        chk_issue("turn_dacc", 2'd1, 32'h500, 64'd0, 1'b0, 1'b1, 4'd2);
        cyc();
        idle();
        ret(4'd2, 64'h3333, 1'b1, 1'b1);
        cyc();
        chk("turn_cnt_d", dut.cnt_d_q, 64'd0);

        // Accept on a still-busy tag (3) flags an error.
        ireq(32'h600);
        mem2proc_response = 4'd3;
        settle();
        chk("coll_acc", icache_req_accept, 1'b1);
        cyc();
        idle();
        chk("coll_err", err_orphan, 1'b1);

        // Reset mid-flight with three loads outstanding.
        do_reset();
        ireq(32'h700);
        mem2proc_response = 4'd1;
        cyc();
        idle();
        dreq(2'd1, 32'h708, 64'd0);
        mem2proc_response = 4'd2;
        cyc();
        idle();
        ireq(32'h710);
        mem2proc_response = 4'd3;
        cyc();
        idle();
        chk("mid_cnt_i", dut.cnt_i_q, 64'd2);
        ret(4'd1, 64'hABCD, 1'b1, 1'b0);
        cyc();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ivld", icache_rsp_valid, 1'b0);
        chk("mid_rst_idata", icache_rsp_data, 64'd0);
        chk("mid_rst_itag", icache_rsp_tag, 4'd0);
        chk("mid_rst_cnt_i", dut.cnt_i_q, 64'd0);
        chk("mid_rst_cnt_d", dut.cnt_d_q, 64'd0);
        chk("mid_rst_cmd", proc2mem_command, 2'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("post_rst_err", err_orphan, 1'b0);
        ret(4'd2, 64'h2BAD, 1'b0, 1'b1);
        cyc();
        chk("post_rst_orphan", err_orphan, 1'b1);
        chk("post_rst_cnt_d", dut.cnt_d_q, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
